// File: rtl/axi_pkg.sv
// Shared AXI4 types and beat-address helper for the on-chip memory slave.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Byte distance between consecutive beats; WRAP deliberately behaves as INCR.
  function automatic logic [7:0] beat_step(input burst_t burst, input logic [2:0] size);
    return (burst == FIXED) ? 8'd0 : (8'd1 << size);
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Word memory with one byte-enabled write port and one registered read port.
// A read and write to the same word in one cycle returns the old contents.
module axi_mem_ram #(
  parameter int unsigned WORDS      = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = $clog2(WORDS)
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_re,
  input  logic [IDX_W-1:0]        i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
    if (i_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/s_axi_mem.sv
// AXI4 slave backed by on-chip word memory; independent single-outstanding write
// and read paths with per-beat range checking.
module s_axi_mem
  import axi_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned          MEM_WORDS  = 1024,
  parameter int unsigned          ID_WIDTH   = 1,
  parameter int unsigned          DATA_WIDTH = 32
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI = LO + (ADDR_WIDTH+1)'(MEM_WORDS * BYTES);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= LO) && ({1'b0, a} < HI);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> OFF_W);
  endfunction

  // Write path
  wr_state_t             r_wstate;
  logic                  r_awready, r_wready, r_bvalid, r_werr;
  resp_t                 r_bresp;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_awlen;
  logic [2:0]            r_awsize;
  burst_t                r_awburst;
  logic [8:0]            r_wcnt;

  logic w_waddr_ok, w_we, w_werr_final;

  assign w_waddr_ok   = in_range(r_waddr);
  assign w_we         = (r_wstate == W_DATA) && s_axi_wvalid && w_waddr_ok;
  assign w_werr_final = r_werr || !w_waddr_ok || (r_wcnt != {1'b0, r_awlen});

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_bid     <= '0;
      r_werr    <= 1'b0;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= INCR;
      r_wcnt    <= '0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            r_bid     <= s_axi_awid;
            r_waddr   <= s_axi_awaddr;
            r_awlen   <= s_axi_awlen;
            r_awsize  <= s_axi_awsize;
            r_awburst <= burst_t'(s_axi_awburst);
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid) begin
            if (!w_waddr_ok) r_werr <= 1'b1;
            r_waddr <= r_waddr + ADDR_WIDTH'(beat_step(r_awburst, r_awsize));
            r_wcnt  <= r_wcnt + 9'd1;
            if (s_axi_wlast) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_werr_final ? SLVERR : OKAY;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read path
  rd_state_t             r_rstate;
  logic                  r_arready, r_rvalid, r_rlast;
  resp_t                 r_rresp;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_arlen, r_rcnt;
  logic [2:0]            r_arsize;
  burst_t                r_arburst;

  logic                  w_re;
  logic [ADDR_WIDTH-1:0] w_rnext, w_rfetch;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // The next word is fetched on the accepting edge so rvalid never drops mid-burst.
  assign w_rnext  = r_raddr + ADDR_WIDTH'(beat_step(r_arburst, r_arsize));
  assign w_rfetch = (r_rstate == R_IDLE) ? s_axi_araddr : w_rnext;
  assign w_re     = ((r_rstate == R_IDLE) && s_axi_arvalid) ||
                    ((r_rstate == R_DATA) && s_axi_rready && !r_rlast);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= OKAY;
      r_rid     <= '0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_rcnt    <= '0;
      r_arsize  <= '0;
      r_arburst <= INCR;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            r_rid     <= s_axi_arid;
            r_raddr   <= s_axi_araddr;
            r_arlen   <= s_axi_arlen;
            r_arsize  <= s_axi_arsize;
            r_arburst <= burst_t'(s_axi_arburst);
            r_rcnt    <= '0;
            r_rvalid  <= 1'b1;
            r_rlast   <= (s_axi_arlen == 8'd0);
            r_rresp   <= in_range(s_axi_araddr) ? OKAY : SLVERR;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr <= w_rnext;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rlast <= ((r_rcnt + 8'd1) == r_arlen);
              r_rresp <= in_range(w_rnext) ? OKAY : SLVERR;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  axi_mem_ram #(
    .WORDS      (MEM_WORDS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .i_clk   (s_axi_aclk),
    .i_we    (w_we),
    .i_waddr (word_idx(r_waddr)),
    .i_wdata (s_axi_wdata),
    .i_wstrb (s_axi_wstrb),
    .i_re    (w_re),
    .i_raddr (word_idx(w_rfetch)),
    .o_rdata (w_ram_rdata)
  );

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_bid;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rid     = r_rid;
  // Out-of-range beats carry SLVERR and must read as zero.
  assign s_axi_rdata   = (r_rresp == SLVERR) ? '0 : w_ram_rdata;

endmodule
